issue_select: RTL
=================

Name: issue_select

Overview:
- Select stage that sits directly downstream of a bank of issue slots.
- Each cycle it arbitrates among the slots' request/priority lines and returns a one-hot grant.
- The granted slot drives the shared read bus in the same cycle; this block captures that micro-op into a single-entry issue register, which feeds the register-read stage.
- It also broadcasts the issued destination register for wakeup, and drops any held micro-op that a branch kill hits.

Parameters:
- NSLOT, 8, number of issue slots arbitrated
- WIDTH_PRY, 2, slot priority width; larger value wins
- WIDTH_REG, 5, physical register index width
- WIDTH_TAG, 5, ROB tag width
- WIDTH_BRM, 3, encoded branch tag width
- WIDTH_O, WIDTH_BRM+WIDTH_TAG+2+3*WIDTH_REG, read-bus width
  - field order from MSB: {BrMask, Tag, bank[1:0], RD, RS2, RS1}

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  reset, asynchronous assert, active-low
- i_request  input  NSLOT  per-slot request; bit k from slot k
- i_priority  input  NSLOT*WIDTH_PRY  slot k priority at bits [(k+1)*WIDTH_PRY-1 : k*WIDTH_PRY]
- o_grant  output  NSLOT  one-hot (or zero) grant, combinational
- i_rslot  input  WIDTH_O  shared bus, driven by the granted slot
- i_brkill  input  2**WIDTH_BRM  one-hot-per-branch kill vector
- i_flush  input  1  synchronous pipeline flush
- i_ready  input  1  register-read stage accepts the held uop this cycle
- o_valid  output  1  issue register holds a live uop
- o_uop  output  WIDTH_O  held uop
- o_wdest  output  WIDTH_REG  RD of the uop being issued; 0 when none

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - o_valid=0, o_uop=0, rr_ptr=0.
  - o_grant=0 while reset is held.
  - Deassertion takes effect at the next edge.
- Kill test: a uop with field BrMask=b is killed when i_brkill[b]=1.
- can_accept = !o_valid | i_ready | held_killed.
  - held_killed = o_valid & i_brkill[o_uop.BrMask].
- Arbitration is combinational and is active only when can_accept=1 and i_flush=0; otherwise o_grant=0.
  - Candidate set = slots with i_request=1.
  - Winner = candidate with maximum priority.
  - Ties go to the first candidate found scanning upward from rr_ptr, wrapping modulo NSLOT.
  - If there are no candidates, o_grant=0.
- Capture at the posedge when any grant bit is set: o_uop <= i_rslot.
  - o_valid <= 1, unless i_brkill hits i_rslot.BrMask in that same cycle, in which case o_valid <= 0.
  - The slot clears itself on grant, so the grant is consumed regardless of the kill.
  - rr_ptr <= (winner+1) mod NSLOT, even if the uop was killed.
- When there is no grant:
  - If o_valid & i_ready, or held_killed: o_valid <= 0.
  - Otherwise the register holds; o_uop is unchanged while stalled.
- i_flush=1: o_valid <= 0 at the edge, no grant that cycle, rr_ptr unchanged.
- Kill of the held uop while stalled (i_ready=0): o_valid drops at the next edge.
  - In that same cycle a new grant is allowed.
- o_wdest = RD field of i_rslot when a grant is active, else 0.
  - It is combinational, same cycle as o_grant, for slot wakeup.
  - Register 0 means "no wakeup".
- Latency: request seen in cycle N → grant in N → o_valid/o_uop in N+1.
  - Throughput is one uop per cycle while i_ready=1.
- Simultaneous o_valid & i_ready & new grant: the register is replaced by the new uop with no bubble.
- If NSLOT is not a power of two, the rr_ptr wrap uses an explicit compare, not bit truncation.

Test Plan:
1. Reset mid-stream with o_valid=1 → o_valid=0 immediately. First request after release on slot 3 (pri 1), bus RD=7 → grant=0x08, o_wdest=7 the same cycle, o_valid=1 with o_uop=bus the next cycle.
2. Slots 1 (pri 1) and 5 (pri 3) request → grant=0x20. Then slots 2 and 6 request, both pri 2, rr_ptr=6 → grant slot 6 first, then slot 2 the next cycle.
3. Round-robin fairness: all 8 slots request with equal priority, continuously, i_ready=1 → grants 0x01,0x02,…,0x80,0x01 on consecutive cycles.
4. Stall: o_valid=1, i_ready=0 for 3 cycles with requests pending → o_grant=0 and o_uop stable. Raise i_ready → the new grant is captured the same cycle with no bubble.
5. Kill: held uop BrMask=2 with i_ready=0; pulse i_brkill=0x04 → o_valid=0 next edge and the pending slot is granted in the kill cycle. Separately, grant a uop with BrMask=5 while i_brkill=0x20 → o_valid stays 0 and rr_ptr still advances.
6. i_flush during active requests → o_grant=0 and o_wdest=0 that cycle, o_valid=0 next cycle, rr_ptr unchanged.

Source files
------------

// File: rtl/issue_select_if.sv
// Slot-bank / issue-register boundary of the select stage: request, priority,
// grant and shared read bus on one side; held uop and ready on the other.
interface issue_select_if #(
  parameter int NSLOT     = 8,
  parameter int WIDTH_PRY = 2,
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_TAG = 5,
  parameter int WIDTH_BRM = 3
);
  localparam int WIDTH_O = WIDTH_BRM + WIDTH_TAG + 2 + 3 * WIDTH_REG;

  logic [NSLOT-1:0]           i_request;
  logic [NSLOT*WIDTH_PRY-1:0] i_priority;
  logic [NSLOT-1:0]           o_grant;
  logic [WIDTH_O-1:0]         i_rslot;
  logic [2**WIDTH_BRM-1:0]    i_brkill;
  logic                       i_flush;
  logic                       i_ready;
  logic                       o_valid;
  logic [WIDTH_O-1:0]         o_uop;
  logic [WIDTH_REG-1:0]       o_wdest;

  modport slave (
    input  i_request, i_priority, i_rslot, i_brkill, i_flush, i_ready,
    output o_grant, o_valid, o_uop, o_wdest
  );

  modport master (
    output i_request, i_priority, i_rslot, i_brkill, i_flush, i_ready,
    input  o_grant, o_valid, o_uop, o_wdest
  );
endinterface

// File: rtl/issue_select.sv
// Priority + round-robin select over the issue slots into a one-entry issue register;
// grant/wakeup same cycle, uop valid next cycle; no grant while the register is stalled, flushed or in reset.
module issue_select #(
  parameter int NSLOT     = 8,
  parameter int WIDTH_PRY = 2,
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_TAG = 5,
  parameter int WIDTH_BRM = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  issue_select_if.slave   bus
);
  localparam int PTR_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef struct packed {
    logic [WIDTH_BRM-1:0] brmask;
    logic [WIDTH_TAG-1:0] tag;
    logic [1:0]           bank;
    logic [WIDTH_REG-1:0] rd;
    logic [WIDTH_REG-1:0] rs2;
    logic [WIDTH_REG-1:0] rs1;
  } uop_t;

  uop_t                 rslot;
  uop_t                 uop_q;
  logic                 valid_q;
  logic [PTR_W-1:0]     rr_ptr;

  logic [WIDTH_PRY-1:0] pri [NSLOT];
  logic [WIDTH_PRY-1:0] max_pri;
  logic [NSLOT-1:0]     grant;
  logic [PTR_W-1:0]     winner;
  logic [PTR_W-1:0]     sidx;
  logic [PTR_W-1:0]     next_ptr;
  logic                 found;
  logic                 grant_any;
  logic                 held_killed;
  logic                 new_killed;
  logic                 can_accept;
  logic                 arb_en;
  int                   idx;

  assign rslot = bus.i_rslot;

  for (genvar g = 0; g < NSLOT; g++) begin : g_pri
    assign pri[g] = bus.i_priority[g*WIDTH_PRY +: WIDTH_PRY];
  end

  // A held uop hit by a kill is dead, so it frees the register this cycle.
  assign held_killed = valid_q & bus.i_brkill[uop_q.brmask];
  assign new_killed  = bus.i_brkill[rslot.brmask];
  assign can_accept  = ~valid_q | bus.i_ready | held_killed;
  assign arb_en      = can_accept & ~bus.i_flush & i_rst_n;

  always_comb begin
    max_pri = '0;
    for (int k = 0; k < NSLOT; k++) begin
      if (bus.i_request[k] && (pri[k] > max_pri)) begin
        max_pri = pri[k];
      end
    end

    // Among max-priority requesters, the first one at or after rr_ptr wins.
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    sidx   = '0;
    for (int i = 0; i < NSLOT; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NSLOT) begin
        idx = idx - NSLOT;
      end
      sidx = PTR_W'(idx);
      if (!found && bus.i_request[sidx] && (pri[sidx] == max_pri)) begin
        found  = 1'b1;
        winner = sidx;
      end
    end

    grant = '0;
    if (found && arb_en) begin
      grant[winner] = 1'b1;
    end
  end

  assign grant_any = |grant;
  assign next_ptr  = (winner == PTR_W'(NSLOT - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      uop_q   <= '0;
      rr_ptr  <= '0;
    end else if (bus.i_flush) begin
      valid_q <= 1'b0;
    end else if (grant_any) begin
      // The slot has already released the uop, so the pointer moves even if it is killed.
      uop_q   <= rslot;
      valid_q <= ~new_killed;
      rr_ptr  <= next_ptr;
    end else if ((valid_q & bus.i_ready) | held_killed) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.o_grant = grant;
  assign bus.o_wdest = grant_any ? rslot.rd : '0;
  assign bus.o_valid = valid_q;
  assign bus.o_uop   = uop_q;
endmodule
